seg_scan_mux: RTL and testbench

//  Downstream display stage for the stopwatch. Takes its four 7-segment digit patterns and

---
 rtl/seg_scan_mux.sv | 116 +++++++++++
 tb/tb_seg_scan_mux.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: four-digit common-anode 7-segment scanner for the stopwatch.
// Each digit owns a DIV-clock slot. The first BLANK clocks of a slot keep all
// anodes off so that the previous digit's pattern cannot ghost. The digit
// patterns and dot are captured once per frame so a frame is never torn.
// Every output is registered, so there is no combinational path from input to output.
module seg_scan_mux #(
    parameter int DIV       = 100000,
    parameter int BLANK     = 1000,
    parameter int DOT_DIGIT = 2
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [6:0] seg1,
    input  logic [6:0] seg2,
    input  logic [6:0] seg3,
    input  logic [6:0] seg4,
    input  logic       dot,
    input  logic       lt,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame
);

    localparam int             CW       = $clog2(DIV);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]  BLANK_C  = CW'(BLANK);
    localparam logic [1:0]     DOT_K    = 2'(DOT_DIGIT);

    logic [1:0]    r_idx;
    logic [CW-1:0] r_cnt;
    logic [6:0]    r_snap [4];   // indexed by anode number: [3] = leftmost
    logic          r_snap_dot;

    logic [3:0]    r_an;
    logic [6:0]    r_seg;
    logic          r_dp;
    logic          r_frame;

    logic [1:0]    w_k;
    logic          w_frame;
    logic [3:0]    w_an;
    logic [6:0]    w_seg;
    logic          w_dp;

    // Slot timing: cnt walks 0..DIV-1 inside a slot, then idx moves to the next digit.
    // NOTE: sequential state is always assigned with <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_idx <= 2'd0;
            r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_cnt <= r_cnt + CNT_ONE;
        end
    end

    // Frame snapshot: inputs are captured only at the very start of slot 0.
    // NOTE: the snapshot array is reset explicitly so a freshly cleared display shows all segments off.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 4; i++) r_snap[i] <= 7'h7F;
            r_snap_dot <= 1'b0;
        end else if (w_frame) begin
            r_snap[3]  <= seg1;
            r_snap[2]  <= seg2;
            r_snap[1]  <= seg3;
            r_snap[0]  <= seg4;
            r_snap_dot <= dot;
        end
    end

    // Next display value from the current slot position, snapshot and lamp test.
    // NOTE: every comb output gets a default first so no latch can be inferred.
    always_comb begin
        w_k     = 2'd3 - r_idx;
        w_frame = (r_idx == 2'd0) && (r_cnt == '0);
        w_an    = 4'hF;
        w_seg   = 7'h7F;
        w_dp    = 1'b1;
        if (r_cnt >= BLANK_C) begin
            w_an = ~(4'b0001 << w_k);
            if (lt) begin
                w_seg = 7'h00;
                w_dp  = 1'b0;
            end else begin
                w_seg = r_snap[w_k];
                w_dp  = ~(r_snap_dot && (w_k == DOT_K));
            end
        end
    end

    // Output register: one cycle behind the slot position, glitch-free at the pins.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_an    <= 4'hF;
            r_seg   <= 7'h7F;
            r_dp    <= 1'b1;
            r_frame <= 1'b0;
        end else begin
            r_an    <= w_an;
            r_seg   <= w_seg;
            r_dp    <= w_dp;
            r_frame <= w_frame;
        end
    end

    assign an    = r_an;
    assign seg   = r_seg;
    assign dp    = r_dp;
    assign frame = r_frame;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Testbench for seg_scan_mux: a time-based reference model predicts every
// output cycle into a queue, and an independent monitor compares the DUT against it.
module tb_seg_scan_mux;

    localparam int DIV       = 8;
    localparam int BLANK     = 2;
    localparam int DOT_DIGIT = 2;
    localparam int FRAME_LEN = 4 * DIV;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic [6:0] seg1 = 7'h40, seg2 = 7'h79, seg3 = 7'h24, seg4 = 7'h30;
    logic       dot = 1'b0;
    logic       lt  = 1'b0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame;

    seg_scan_mux #(.DIV(DIV), .BLANK(BLANK), .DOT_DIGIT(DOT_DIGIT)) dut (
        .clk(clk), .clr(clr),
        .seg1(seg1), .seg2(seg2), .seg3(seg3), .seg4(seg4),
        .dot(dot), .lt(lt),
        .an(an), .seg(seg), .dp(dp), .frame(frame)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       frame;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: elapsed clocks since clr release and the frame's captured inputs.
    int         m_t = 0;
    logic [6:0] m_pat [4];
    logic       m_dot = 1'b0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp_v);
        end
    endtask

    // Predict what the DUT shows after the coming edge, given the inputs now applied.
    task automatic model_edge();
        exp_t e;
        int   digit;
        int   pos;
        if (clr) begin
            e = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, frame: 1'b0};
            m_t = 0;
            for (int i = 0; i < 4; i++) m_pat[i] = 7'h7F;
            m_dot = 1'b0;
        end else begin
            digit = 3 - ((m_t / DIV) % 4);   // anode number lit in this slot
            pos   = m_t % DIV;
            e.frame = ((m_t % FRAME_LEN) == 0);
            if (pos < BLANK) begin
                e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1;
            end else begin
                e.an = 4'hF;
                e.an[digit] = 1'b0;
                e.seg = lt ? 7'h00 : m_pat[digit];
                e.dp  = lt ? 1'b0 : !(m_dot && digit == DOT_DIGIT);
            end
            if (e.frame) begin
                m_pat[3] = seg1; m_pat[2] = seg2; m_pat[1] = seg3; m_pat[0] = seg4;
                m_dot = dot;
            end
            m_t++;
        end
        q.push_back(e);
    endtask

    task automatic step(input logic c, input logic d, input logic l);
        @(negedge clk);
        clr = c; dot = d; lt = l;
        model_edge();
    endtask

    // Monitor: after each edge pop one prediction and compare all outputs.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("an",    {12'h0, an},    {12'h0, e.an});
                check("seg",   {9'h0, seg},    {9'h0, e.seg});
                check("dp",    {15'h0, dp},    {15'h0, e.dp});
                check("frame", {15'h0, frame}, {15'h0, e.frame});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4; i++) m_pat[i] = 7'h7F;
        // Reset held for three edges.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
        // Plain scan, then the dot enabled, one frame each.
        for (int i = 0; i < FRAME_LEN; i++) step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < FRAME_LEN; i++) step(1'b0, 1'b1, 1'b0);
        // Change seg1 while the second digit is lit; it must wait for the next frame.
        for (int i = 0; i < 2 * FRAME_LEN; i++) begin
            @(negedge clk);
            if (i == DIV + 4) seg1 = 7'h12;
            clr = 1'b0; dot = 1'b1; lt = 1'b0;
            model_edge();
        end
        // Lamp test for one frame.
        for (int i = 0; i < FRAME_LEN; i++) step(1'b0, 1'b0, 1'b1);
        // Mid-scan clear at slot 2, cnt 5, then restart.
        for (int i = 0; i < 2 * DIV + 5; i++) step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < FRAME_LEN + 8; i++) step(1'b0, 1'b1, 1'b0);
        // Random inputs, including occasional clears and lamp test.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            seg1 = 7'($urandom); seg2 = 7'($urandom);
            seg3 = 7'($urandom); seg4 = 7'($urandom);
            dot  = 1'($urandom);
            lt   = ($urandom_range(0, 7) == 0);
            clr  = ($urandom_range(0, 63) == 0);
            model_edge();
        end
        @(posedge clk);
        #2;
        check("queue_drained", 16'(q.size()), 16'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
